tkm_serial_adder: RTL
=====================

# tkm_serial_adder

Parametrised bit-serial add/subtract unit; the sequential successor to our single-bit combinational half-adder cell. It streams operands one bit per cycle through a single full-adder slice (carry held in a flip-flop). It returns a WIDTH-bit sum with carry-out and signed overflow under a start/busy/done handshake. It sits behind the top-level pin wrapper, which maps operand and control pins onto its ports.

## Interface

- WIDTH, default 8: operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- ena  input  1  clock enable; low freezes all state; start is ignored while low.
- start  input  1  request a new operation; sampled only in IDLE or DONE with ena high.
- sub  input  1  0 = a+b, 1 = a−b; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; result outputs valid from this cycle.
- sum  output  WIDTH  registered result; holds until the next completion.
- cout  output  1  carry out of the MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation

- Reset (async, rst_n low): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal shift registers, carry and counter cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on start=1 (ena=1): latch A, B' = sub ? ~b : b, carry = sub, count = 0; go to RUN.
  - RUN: each enabled cycle compute full-adder on A[0], B'[0], carry. Shift the result bit into the MSB of the accumulating shift register and shift A and B' right by one. Update carry and increment count. On the step where count = WIDTH−1, also capture carry-in as c_msb. Then write sum, cout = new carry, and ovf = c_msb XOR new carry. Go to DONE.
  - DONE: done=1 for exactly one enabled cycle. If start=1 in this cycle, accept it exactly as in IDLE and go to RUN (back-to-back); otherwise go to IDLE.
- start is ignored in RUN; no queuing.
- sum, cout and ovf change only on the completion edge; they hold their previous result throughout RUN.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

## Timing

- Start accepted at edge k. busy is high from cycle k+1 through the edge at k+WIDTH. done and the new sum/cout/ovf are visible after edge k+WIDTH; the latency is WIDTH cycles.
- Throughput: one result every WIDTH+1 cycles with back-to-back starts.
- ena=0: no state, counter, carry or output register changes. A done pulse in progress stretches until ena returns high.
- rst_n asserted mid-RUN: immediate abort to IDLE with all outputs cleared. The first operation accepted after release completes normally.
- start with ena=0 at the sampling edge is lost; it is not remembered.

## Test plan

- WIDTH=8, add 0x5A+0x33 -> after 8 cycles done=1, sum=0x8D, cout=0, ovf=1; busy high for exactly 8 cycles.
- WIDTH=8, add 0xFF+0x01 -> sum=0x00, cout=1, ovf=0. Sub 0x10−0x20 -> sum=0xF0, cout=0, ovf=0. Sub 0x80−0x01 -> sum=0x7F, cout=1, ovf=1.
- Back-to-back: start held high through DONE with the next operands 0x01+0x01 -> second done exactly 9 cycles after the first, sum=0x02. A start pulse mid-RUN -> ignored, and the result is unchanged.
- ena toggled low for 3 cycles mid-RUN -> done delayed by exactly 3 cycles, and the result is identical to the uninterrupted run.
- rst_n pulsed low at cycle 4 of RUN -> busy, done, sum, cout and ovf are 0 immediately. A subsequent 0x22+0x11 gives sum=0x33.
- WIDTH=4 instance: 0x7+0x1 -> sum=0x8, cout=0, ovf=1 after 4 cycles. Random-operand sweep (both widths, both modes) is checked against the reference model a±b mod 2^WIDTH.

Source files
------------

// File: rtl/tkm_serial_adder.sv
// Bit-serial add/subtract: one full-adder slice with a registered carry, WIDTH cycles per result.
// The result registers update only on the completion edge and hold through the next run.
module tkm_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef struct packed {
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           state, state_nxt;
  req_t             req;
  logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             accept, step, last;
  logic             fa_s, fa_c;

  assign req     = '{sub: sub, a: a, b: b};
  assign accept  = ena & start & ((state == IDLE) | (state == DONE));
  assign step    = ena & (state == RUN);
  assign last    = (cnt == CW'(WIDTH - 1));

  // single full-adder slice; carry into the MSB is the registered carry on the last step
  assign fa_s    = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_c    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  assign acc_nxt = {fa_s, acc[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state <= IDLE;
    else if (ena) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      // subtraction as a + ~b + 1: the +1 rides in on the initial carry
      a_sh  <= req.a;
      b_sh  <= req.sub ? ~req.b : req.b;
      acc   <= '0;
      carry <= req.sub;
      cnt   <= '0;
    end else if (step) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      acc   <= acc_nxt;
      carry <= fa_c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum  <= acc_nxt;
        cout <= fa_c;
        ovf  <= carry ^ fa_c;
      end
    end
  end

endmodule
